farm_sensor_conditioner: RTL and testbench

Upstream stage of the highway/farm-road traffic light controller. Produces that controller's farm_sensor_X request input from the raw farm-road vehicle loop detector. The block synchronises and debounces the raw sensor, then shapes the request:
- guaranteed minimum farm-green request time
- capped maximum request time
- cooldown so the highway always regains green

All timing counts ticks of an external timebase enable.

---
 rtl/farm_sensor_conditioner.sv | 228 ++++++++++++++++++++++
 tb/tb_farm_sensor_conditioner.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/farm_sensor_conditioner.sv
// ============================================================================
// Module   : farm_sensor_conditioner
// Purpose  : Synchronises and debounces the farm-road loop detector, then
//            shapes the farm_sensor_X request for the highway/farm-road light
//            controller: guaranteed minimum request time, capped maximum
//            request time and a cooldown so the highway regains green.
//            All timing counts ticks of an external timebase enable.
// Options  : FARM_STUCK_DETECT_EN - stuck-sensor detector; raises a sticky
//            sensor_fault and blocks further requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module farm_sensor_conditioner #(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int MIN_HOLD_TICKS = 8,
    parameter int MAX_HOLD_TICKS = 20,
    parameter int COOLDOWN_TICKS = 6,
    parameter int CNT_W          = 8,
    parameter int STUCK_TICKS    = 200
) (
    input  logic clk,
    input  logic rst,              // asynchronous, active-low
    input  logic tick,
    input  logic sensor_raw,
    output logic farm_sensor_X,
    output logic vehicle_present,
    output logic max_timeout,
    output logic sensor_fault
);

    // Terminal counts; every timer compare is an equality against these.
    localparam logic [CNT_W-1:0] c_DB_LAST    = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] c_MIN_LAST   = CNT_W'(MIN_HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] c_MAX_LAST   = CNT_W'(MAX_HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] c_CD_LAST    = (COOLDOWN_TICKS > 0) ?
                                                CNT_W'(COOLDOWN_TICKS - 1) : '0;
    localparam bit               c_CD_ZERO    = (COOLDOWN_TICKS == 0);
    localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);

    // Parameter legality, caught at elaboration.
    if (DEBOUNCE_TICKS < 1) begin : g_chk_debounce
        $error("DEBOUNCE_TICKS must be >= 1 (got %0d)", DEBOUNCE_TICKS);
    end
    if (MIN_HOLD_TICKS < 1) begin : g_chk_min_hold
        $error("MIN_HOLD_TICKS must be >= 1 (got %0d)", MIN_HOLD_TICKS);
    end
    if (MAX_HOLD_TICKS < MIN_HOLD_TICKS) begin : g_chk_max_hold
        $error("MAX_HOLD_TICKS must be >= MIN_HOLD_TICKS");
    end
    if ((MAX_HOLD_TICKS >= (1 << CNT_W)) || (STUCK_TICKS >= (1 << CNT_W)) ||
        (COOLDOWN_TICKS >= (1 << CNT_W))) begin : g_chk_width
        $error("CNT_W too narrow for MAX_HOLD_TICKS/STUCK_TICKS/COOLDOWN_TICKS");
    end
    if (STUCK_TICKS < 1) begin : g_chk_stuck
        $error("STUCK_TICKS must be >= 1 (got %0d)", STUCK_TICKS);
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MIN_HOLD = 2'd1,
        ST_EXTEND   = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_db_cnt;
    logic             r_vehicle_present;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_hold_tmr;
    logic [CNT_W-1:0] w_hold_nxt;
    logic [CNT_W-1:0] r_cd_tmr;
    logic [CNT_W-1:0] w_cd_nxt;
    logic             w_max_hit;
    logic             r_farm;
    logic             r_max_timeout;

    logic             w_stuck_hit;    // stuck threshold reached this cycle
    logic             w_fault_block;  // suppress new requests

    // Two-flop synchroniser followed by a tick-based debounce counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1           <= 1'b0;
            r_sync2           <= 1'b0;
            r_db_cnt          <= '0;
            r_vehicle_present <= 1'b0;
        end else begin
            r_sync1 <= sensor_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_vehicle_present) begin
                r_db_cnt <= '0;
            end else if (tick) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_vehicle_present <= ~r_vehicle_present;
                    r_db_cnt          <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + c_ONE;
                end
            end
        end
    end

    // Request-shaping state register, timers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_hold_tmr    <= '0;
            r_cd_tmr      <= '0;
            r_farm        <= 1'b0;
            r_max_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_hold_tmr    <= w_hold_nxt;
            r_cd_tmr      <= w_cd_nxt;
            r_farm        <= (w_state_nxt == ST_MIN_HOLD) ||
                             (w_state_nxt == ST_EXTEND);
            r_max_timeout <= w_max_hit;
        end
    end

    // Next-state and timer logic; the cap check in EXTEND takes priority
    // over the vehicle-gone release so a simultaneous event still pulses.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_tmr;
        w_cd_nxt    = r_cd_tmr;
        w_max_hit   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_vehicle_present && !w_fault_block) begin
                    w_state_nxt = ST_MIN_HOLD;
                    w_hold_nxt  = '0;
                end
            end
            ST_MIN_HOLD: begin
                if (tick) begin
                    w_hold_nxt = r_hold_tmr + c_ONE;
                    if (r_hold_tmr == c_MIN_LAST) begin
                        // When MIN and MAX coincide the cap is reached here.
                        if (r_hold_tmr == c_MAX_LAST) begin
                            w_state_nxt = ST_COOLDOWN;
                            w_cd_nxt    = '0;
                            w_max_hit   = 1'b1;
                        end else begin
                            w_state_nxt = ST_EXTEND;
                        end
                    end
                end
            end
            ST_EXTEND: begin
                if (tick) begin
                    w_hold_nxt = r_hold_tmr + c_ONE;
                end
                if (tick && (r_hold_tmr == c_MAX_LAST)) begin
                    w_state_nxt = ST_COOLDOWN;
                    w_cd_nxt    = '0;
                    w_max_hit   = 1'b1;
                end else if (!r_vehicle_present) begin
                    w_state_nxt = ST_COOLDOWN;
                    w_cd_nxt    = '0;
                end
            end
            ST_COOLDOWN: begin
                if (c_CD_ZERO) begin
                    w_state_nxt = ST_IDLE;
                end else if (tick) begin
                    w_cd_nxt = r_cd_tmr + c_ONE;
                    if (r_cd_tmr == c_CD_LAST) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // A newly detected stuck sensor ends any request immediately.
        if (w_stuck_hit) begin
            w_state_nxt = ST_COOLDOWN;
            w_cd_nxt    = '0;
        end
    end

`ifdef FARM_STUCK_DETECT_EN
    localparam logic [CNT_W-1:0] c_STUCK_LAST = CNT_W'(STUCK_TICKS - 1);

    logic [CNT_W-1:0] r_stuck_tmr;
    logic             r_sensor_fault;

    assign w_stuck_hit   = tick && r_vehicle_present && !r_sensor_fault &&
                           (r_stuck_tmr == c_STUCK_LAST);
    assign w_fault_block = r_sensor_fault;

    // Stuck-sensor timer; the fault is sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stuck_tmr    <= '0;
            r_sensor_fault <= 1'b0;
        end else begin
            if (!r_vehicle_present) begin
                r_stuck_tmr <= '0;
            end else if (tick && !r_sensor_fault) begin
                r_stuck_tmr <= r_stuck_tmr + c_ONE;
            end
            if (w_stuck_hit) begin
                r_sensor_fault <= 1'b1;
            end
        end
    end

    assign sensor_fault = r_sensor_fault;
`else
    assign w_stuck_hit   = 1'b0;
    assign w_fault_block = 1'b0;
    assign sensor_fault  = 1'b0;
`endif

    assign farm_sensor_X   = r_farm;
    assign vehicle_present = r_vehicle_present;
    assign max_timeout     = r_max_timeout;

endmodule

`default_nettype wire

// File: tb/tb_farm_sensor_conditioner.sv
// ============================================================================
// Module   : tb_farm_sensor_conditioner
// Purpose  : Directed self-checking bench for farm_sensor_conditioner using
//            default parameters and tick=1 every cycle. Cycle indices k are
//            counted in rising edges after the stimulus reference point.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_farm_sensor_conditioner;

    logic clk        = 1'b0;
    logic rst        = 1'b0;
    logic tick       = 1'b1;
    logic sensor_raw = 1'b0;
    logic farm_sensor_X;
    logic vehicle_present;
    logic max_timeout;
    logic sensor_fault;

    int n_total = 0;
    int n_bad   = 0;

    farm_sensor_conditioner dut (
        .clk             (clk),
        .rst             (rst),
        .tick            (tick),
        .sensor_raw      (sensor_raw),
        .farm_sensor_X   (farm_sensor_X),
        .vehicle_present (vehicle_present),
        .max_timeout     (max_timeout),
        .sensor_fault    (sensor_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset with vehicle present on the raw input
        rst        = 1'b0;
        sensor_raw = 1'b1;
        repeat (3) step();
        check("rst_farm",  farm_sensor_X,   0);
        check("rst_vp",    vehicle_present, 0);
        check("rst_max",   max_timeout,     0);
        check("rst_fault", sensor_fault,    0);

        // ---------------- long vehicle straight out of reset
        // vp rises at k=6, request k=7..26 (20 cycles), cap pulse k=27,
        // cooldown k=27..32, IDLE at k=33, re-request from k=34.
        rst = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            step();
            check($sformatf("long_vp_%0d", k), vehicle_present, (k >= 6));
            check($sformatf("long_farm_%0d", k), farm_sensor_X,
                  ((k >= 7) && (k <= 26)) || (k >= 34));
            check($sformatf("long_max_%0d", k), max_timeout, (k == 27));
        end

        // ---------------- mid-hold asynchronous reset (hold cycle 10)
        repeat (8) step();
        check("mid_pre_farm", farm_sensor_X, 1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_async_farm", farm_sensor_X,   0);
        check("mid_async_vp",   vehicle_present, 0);
        sensor_raw = 1'b0;
        step();
        step();
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("mid_post_farm_%0d", k), farm_sensor_X, 0);
            check($sformatf("mid_post_max_%0d", k),  max_timeout,   0);
        end

        // ---------------- glitch: raw high for 3 cycles only
        sensor_raw = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 3) sensor_raw = 1'b0;
            check($sformatf("glitch_vp_%0d", k),   vehicle_present, 0);
            check($sformatf("glitch_farm_%0d", k), farm_sensor_X,   0);
        end

        // ---------------- short vehicle: raw high for 5 cycles
        // vp high k=6..10. Request k=7..15: 8 MIN_HOLD cycles plus the one
        // EXTEND cycle in which the departed vehicle is observed.
        // Cooldown k=16..21, no cap pulse.
        sensor_raw = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (k == 5) sensor_raw = 1'b0;
            check($sformatf("short_vp_%0d", k), vehicle_present,
                  (k >= 6) && (k <= 10));
            check($sformatf("short_farm_%0d", k), farm_sensor_X,
                  (k >= 7) && (k <= 15));
            check($sformatf("short_max_%0d", k),   max_timeout,  0);
            check($sformatf("short_fault_%0d", k), sensor_fault, 0);
        end

`ifdef FARM_STUCK_DETECT_EN
        // ---------------- stuck sensor: raw held high
        // vp rises at k=6; 200th tick with vp=1 is edge k=206.
        rst        = 1'b0;
        sensor_raw = 1'b1;
        step();
        step();
        rst = 1'b1;
        for (int k = 1; k <= 270; k++) begin
            step();
            if (k == 205) check("stuck_fault_pre", sensor_fault, 0);
            if (k >= 206) begin
                check($sformatf("stuck_fault_%0d", k), sensor_fault,  1);
                check($sformatf("stuck_farm_%0d", k),  farm_sensor_X, 0);
            end
        end
        rst = 1'b0;
        #1;
        check("stuck_rst_clear", sensor_fault, 0);
        rst = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
